tdm_demux_rx: RTL
=================

// Module: tdm_demux_rx
// PURPOSE
//   Receive end of the lab's serial time-division-multiplexed (TDM) link.
//   The transmitter uses yMux-style channel selection to serialize CH channels
//   of W bits each onto one wire, MSB first, channel 0 first.
//   This block de-serializes that stream back into CH parallel W-bit words.
//   It presents each complete frame atomically, with a one-cycle valid pulse.
// PARAMETERS
//   CH   4   number of channels per frame (>=2)
//   W    8   bits per channel (>=2)
// PORTS
//   clk          in   1      rising-edge clock; the only clock
//   reset        in   1      asynchronous, active-high reset
//   en           in   1      bit strobe: din/sync are sampled only when en=1
//   sync         in   1      frame marker; qualified by en; marks bit 0 of channel 0
//   din          in   1      serial data bit
//   dout         out  CH*W   last complete frame; channel k at dout[k*W +: W]
//   frame_valid  out  1      one-cycle pulse: dout was just updated
//   sync_err     out  1      one-cycle pulse: sync arrived mid-frame
//   busy         out  1      1 while in RECV state
// BEHAVIOUR
//   Reset (async, active-high):
//     - dout=0, frame_valid=0, sync_err=0, busy=0.
//     - State=HUNT; counters=0; shadow register=0.
//   All outputs are registered; nothing is combinational from inputs.
//   Counters:
//     - bit_cnt runs 0..W-1; ch_cnt runs 0..CH-1.
//     - Widths are $clog2 of each range, minimum 1 bit.
//   Shift rule:
//     - Each accepted bit shifts into shadow[ch_cnt*W +: W] from the LSB end.
//     - The first bit received becomes the channel's MSB.
//   State HUNT:
//     - en=1 && sync=0: bit discarded, stay in HUNT.
//     - en=1 && sync=1: din stored as bit 0 of ch 0; bit_cnt=1, ch_cnt=0; go to RECV.
//   State RECV, en=1 && sync=0:
//     - Shift din in and advance bit_cnt.
//     - When bit_cnt wraps from W-1, ch_cnt increments.
//     - On the last bit (ch_cnt=CH-1, bit_cnt=W-1):
//       - Full frame including this bit copied to dout at that same edge.
//       - frame_valid=1 for exactly the next cycle.
//       - State returns to HUNT.
//   State RECV, en=1 && sync=1 (resync):
//     - Partial frame discarded; dout unchanged.
//     - sync_err=1 for one cycle.
//     - Current din taken as bit 0 of ch 0 of a new frame; stays in RECV.
//   en=0 in any state:
//     - No state, counter or shadow change.
//     - frame_valid/sync_err pulses still clear after their single cycle.
//   Back-to-back frames:
//     - A sync on the en cycle right after the last bit is legal.
//     - No gap is required.
//   Shadow vs. output:
//     - Shadow is never visible on dout until the frame completes.
//     - A frame aborted by resync or reset never reaches dout.
//   Reset mid-frame: immediate return to reset values; partial data is lost.
//   Latency: last bit sampled at edge N -> dout and frame_valid valid after edge N.
//   Width rule: dout width is exactly CH*W; there is no padding.
// TESTING
//   1. Reset, then assert no stimulus:
//      -> dout=0, frame_valid=0, busy=0 for 20 cycles.
//   2. CH=4, W=8: send frame 0xA5,0x3C,0xFF,0x01 with en=1 every cycle, sync on first bit:
//      -> dout=32'h01FF3CA5 and a 1-cycle frame_valid exactly 32 cycles after sync.
//   3. Same frame with en=1 only every 3rd cycle:
//      -> identical dout; frame_valid a single cycle after the 32nd strobe.
//   4. Frame 0x11,0x22,0x33,0x44 followed back-to-back by 0x55,0x66,0x77,0x88:
//      -> two frame_valid pulses 32 en-cycles apart;
//      -> dout=32'h44332211, then 32'h88776655.
//   5. Resync and HUNT discard:
//      - Sync, 13 bits, sync again, then full frame 0xDE,0xAD,0xBE,0xEF:
//        -> sync_err pulse at bit 14; dout=32'hEFBEADDE; no valid for the aborted frame.
//      - 10 strobed bits without sync: -> no effect.
//   6. Assert reset mid-frame (after 20 bits of a frame):
//      -> all outputs 0 asynchronously; busy=0.
//      -> The next synced frame 0x01,0x02,0x03,0x04 gives dout=32'h04030201.

Source files
------------

// File: rtl/tdm_demux_rx_if.sv
// Purpose : bundle of the serial TDM receive-side signals (bit strobe, marker, data in; frame out).
// Latency : n/a (signal bundle only).
// Backpressure: none; the link is strobe-driven and the receiver always accepts.
//
// Ports / signals:
//   en, sync, din           serial side, driven by the link (master) into the receiver (slave)
//   dout, frame_valid,      parallel frame side, driven by the receiver (slave)
//   sync_err, busy
interface tdm_demux_rx_if #(
  parameter int CH = 4,
  parameter int W  = 8
);
  logic            en;
  logic            sync;
  logic            din;
  logic [CH*W-1:0] dout;
  logic            frame_valid;
  logic            sync_err;
  logic            busy;

  // Link side: drives the serial stream, observes the recovered frames.
  modport master (
    output en, sync, din,
    input  dout, frame_valid, sync_err, busy
  );

  // Receiver side.
  modport slave (
    input  en, sync, din,
    output dout, frame_valid, sync_err, busy
  );
endinterface

// File: rtl/tdm_demux_rx.sv
// Purpose : de-serialize a CH x W-bit TDM frame (MSB first, channel 0 first) into one parallel word.
// Latency : last bit sampled at edge N -> dout/frame_valid valid after edge N (all outputs registered).
// Backpressure: none; bits are consumed on every en strobe, frames are presented as a 1-cycle pulse.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous, active-high reset
//   bus.en            bit strobe; sync/din are ignored when low
//   bus.sync          frame marker, marks bit 0 of channel 0
//   bus.din           serial data bit
//   bus.dout          last complete frame, channel k at dout[k*W +: W]
//   bus.frame_valid   1-cycle pulse: dout just updated
//   bus.sync_err      1-cycle pulse: marker arrived mid-frame
//   bus.busy          high while a frame is being received
module tdm_demux_rx #(
  parameter int CH = 4,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          reset,
  tdm_demux_rx_if.slave bus
);

  localparam int BW = (W  > 1) ? $clog2(W)  : 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(CH - 1);

  localparam logic [0:0] S_HUNT = 1'b0;
  localparam logic [0:0] S_RECV = 1'b1;

  logic [0:0]       r_state;
  logic [BW-1:0]    r_bit_cnt;
  logic [CW-1:0]    r_ch_cnt;
  logic [CH*W-1:0]  r_shadow;
  logic [CH*W-1:0]  r_dout;
  logic             r_frame_valid;
  logic             r_sync_err;

  logic             w_start;
  logic             w_shift;
  logic [CW-1:0]    w_idx;
  logic [W-1:0]     w_slot;
  logic [CH*W-1:0]  w_next_shadow;

  // A strobed marker always starts a new frame, in either state.
  assign w_start = bus.en & bus.sync;
  // Plain data bits only matter once a frame has been started.
  assign w_shift = bus.en & ~bus.sync & (r_state == S_RECV);

  // The marker bit always lands in channel 0, whatever the counter says.
  assign w_idx  = w_start ? '0 : r_ch_cnt;
  assign w_slot = r_shadow[w_idx*W +: W];

  // Shadow with the current bit shifted in; used both for the shadow update
  // and for the dout copy so the final bit is included in the same edge.
  always_comb begin
    w_next_shadow                = r_shadow;
    w_next_shadow[w_idx*W +: W]  = {w_slot[W-2:0], bus.din};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_HUNT;
      r_bit_cnt     <= '0;
      r_ch_cnt      <= '0;
      r_shadow      <= '0;
      r_dout        <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      if (w_start) begin
        // Partial frame (if any) is abandoned; dout is left alone.
        r_shadow  <= w_next_shadow;
        r_bit_cnt <= BW'(1);
        r_ch_cnt  <= '0;
        r_state   <= S_RECV;
        if (r_state == S_RECV) begin
          r_sync_err <= 1'b1;
        end
      end else if (w_shift) begin
        r_shadow <= w_next_shadow;
        if (r_bit_cnt == LAST_BIT) begin
          r_bit_cnt <= '0;
          if (r_ch_cnt == LAST_CH) begin
            r_ch_cnt      <= '0;
            r_state       <= S_HUNT;
            r_dout        <= w_next_shadow;
            r_frame_valid <= 1'b1;
          end else begin
            r_ch_cnt <= r_ch_cnt + 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.dout        = r_dout;
  assign bus.frame_valid = r_frame_valid;
  assign bus.sync_err    = r_sync_err;
  assign bus.busy        = (r_state == S_RECV);

endmodule
